// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register bank.
// - stat codes, NOP icode and the "no register" id
// - bus widths and field offsets as functions of the datapath word width
// - per-stage bubble constants (returned zero-extended to BUS_MAX bits;
//   callers keep the low <stage>_w(word) bits)
package pipe_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] RNONE     = 4'hF;

  // Widest bus the bubble helpers can describe (E bus at WORD=256).
  localparam int BUS_MAX = 27 + 3 * 256;

  // Bus widths. Fields are packed MSB-first in the order listed at each port.
  function automatic int d_w(input int word); return 19 + 2 * word; endfunction
  function automatic int e_w(input int word); return 27 + 3 * word; endfunction
  function automatic int m_w(input int word); return 16 + 2 * word; endfunction
  function automatic int w_w(input int word); return 15 + 2 * word; endfunction

  // stat always sits in the top three bits, icode in the next four.
  function automatic int stat_lsb(input int bus_w); return bus_w - 3; endfunction
  function automatic int icode_lsb(input int bus_w); return bus_w - 7; endfunction

  // E bus register ids in the low 16 bits: {dstE, dstM, srcA, srcB}.
  function automatic int e_dste_lsb(input int word); return 12 + 0 * word; endfunction
  function automatic int e_dstm_lsb(input int word); return 8 + 0 * word; endfunction

  // {stat, icode, ifun, rA, rB} above two zero words.
  function automatic logic [BUS_MAX-1:0] d_bubble(input int word);
    logic [BUS_MAX-1:0] r;
    r = '0;
    r[2*word +: 19] = {STAT_AOK, ICODE_NOP, 4'h0, RNONE, RNONE};
    return r;
  endfunction

  // {stat, icode, ifun} above three zero words, then dstE/dstM/srcA/srcB.
  function automatic logic [BUS_MAX-1:0] e_bubble(input int word);
    logic [BUS_MAX-1:0] r;
    r = '0;
    r[16+3*word +: 11] = {STAT_AOK, ICODE_NOP, 4'h0};
    r[15:0] = {RNONE, RNONE, RNONE, RNONE};
    return r;
  endfunction

  // {stat, icode, Cnd} above two zero words, then dstE/dstM.
  function automatic logic [BUS_MAX-1:0] m_bubble(input int word);
    logic [BUS_MAX-1:0] r;
    r = '0;
    r[8+2*word +: 8] = {STAT_AOK, ICODE_NOP, 1'b0};
    r[7:0] = {RNONE, RNONE};
    return r;
  endfunction

  // {stat, icode} above two zero words, then dstE/dstM.
  function automatic logic [BUS_MAX-1:0] w_bubble(input int word);
    logic [BUS_MAX-1:0] r;
    r = '0;
    r[8+2*word +: 7] = {STAT_AOK, ICODE_NOP};
    r[7:0] = {RNONE, RNONE};
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_cell.sv
// One pipeline register with hold/bubble/load priority.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset (q <= BUBBLE)
//   freeze    - hold unconditionally (pipeline halted)
//   stall     - hold
//   bubble    - load BUBBLE
//   d         - next-stage value, loaded when none of the above apply
//   q         - registered output
// Reset also loads BUBBLE; for the F register BUBBLE carries the reset PC
// since its bubble input is tied low.
module pipe_reg_cell #(
  parameter int           W      = 8,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)         q <= BUBBLE;
    else if (freeze) q <= q;
    else if (stall)  q <= q;
    else if (bubble) q <= BUBBLE;
    else             q <= d;
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// F/D/E/M/W pipeline register bank driven by the hazard-control unit.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   F_stall, D_stall, W_stall        - hold the named register
//   D_bubble, E_bubble, M_bubble     - load the stage NOP bubble
//   f_predPC, d_in, e_in, m_in, w_in - next values for F, D, E, M, W
//   F_predPC, D_bus .. W_bus         - register outputs
//   halted     - sticky; set when W is stalled holding HLT/ADR/INS
//   ctl_err    - sticky; D stall+bubble together, or W stall on AOK
//   stall_cnt  - saturating count of F_stall cycles while running
//   bubble_cnt - saturating count of E_bubble cycles while running
// All outputs are registered.
module pipe_stage_regs
  import pipe_pkg::*;
#(
  parameter int              WORD     = 64,
  parameter int              CNT_W    = 32,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   F_stall,
  input  logic                   D_stall,
  input  logic                   D_bubble,
  input  logic                   E_bubble,
  input  logic                   M_bubble,
  input  logic                   W_stall,
  input  logic [WORD-1:0]        f_predPC,
  input  logic [d_w(WORD)-1:0]   d_in,
  input  logic [e_w(WORD)-1:0]   e_in,
  input  logic [m_w(WORD)-1:0]   m_in,
  input  logic [w_w(WORD)-1:0]   w_in,
  output logic [WORD-1:0]        F_predPC,
  output logic [d_w(WORD)-1:0]   D_bus,
  output logic [e_w(WORD)-1:0]   E_bus,
  output logic [m_w(WORD)-1:0]   M_bus,
  output logic [w_w(WORD)-1:0]   W_bus,
  output logic                   halted,
  output logic                   ctl_err,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
);

  localparam int DW = d_w(WORD);
  localparam int EW = e_w(WORD);
  localparam int MW = m_w(WORD);
  localparam int WW = w_w(WORD);

  localparam logic [BUS_MAX-1:0] D_FULL = d_bubble(WORD);
  localparam logic [BUS_MAX-1:0] E_FULL = e_bubble(WORD);
  localparam logic [BUS_MAX-1:0] M_FULL = m_bubble(WORD);
  localparam logic [BUS_MAX-1:0] W_FULL = w_bubble(WORD);
  localparam logic [DW-1:0] D_BUB = D_FULL[DW-1:0];
  localparam logic [EW-1:0] E_BUB = E_FULL[EW-1:0];
  localparam logic [MW-1:0] M_BUB = M_FULL[MW-1:0];
  localparam logic [WW-1:0] W_BUB = W_FULL[WW-1:0];

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pipe_reg_cell #(.W(WORD), .BUBBLE(RESET_PC)) u_f (
    .clk(clk), .rst(rst), .freeze(halted), .stall(F_stall), .bubble(1'b0),
    .d(f_predPC), .q(F_predPC));

  pipe_reg_cell #(.W(DW), .BUBBLE(D_BUB)) u_d (
    .clk(clk), .rst(rst), .freeze(halted), .stall(D_stall), .bubble(D_bubble),
    .d(d_in), .q(D_bus));

  pipe_reg_cell #(.W(EW), .BUBBLE(E_BUB)) u_e (
    .clk(clk), .rst(rst), .freeze(halted), .stall(1'b0), .bubble(E_bubble),
    .d(e_in), .q(E_bus));

  pipe_reg_cell #(.W(MW), .BUBBLE(M_BUB)) u_m (
    .clk(clk), .rst(rst), .freeze(halted), .stall(1'b0), .bubble(M_bubble),
    .d(m_in), .q(M_bus));

  pipe_reg_cell #(.W(WW), .BUBBLE(W_BUB)) u_w (
    .clk(clk), .rst(rst), .freeze(halted), .stall(W_stall), .bubble(1'b0),
    .d(w_in), .q(W_bus));

  logic [2:0] w_stat;
  logic       halt_now;
  logic       err_now;

  // Halt is judged on the registered W stat so it lines up with the edge
  // at which W is being held; the bank freezes from the following edge.
  always_comb begin
    w_stat   = W_bus[stat_lsb(WW) +: 3];
    halt_now = W_stall && (w_stat inside {STAT_HLT, STAT_ADR, STAT_INS});
    err_now  = (D_stall && D_bubble) || (W_stall && (w_stat == STAT_AOK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted     <= 1'b0;
      ctl_err    <= 1'b0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!halted) begin
      halted <= halt_now;
      if (err_now) ctl_err <= 1'b1;
      if (F_stall && !(&stall_cnt))   stall_cnt  <= stall_cnt + CNT_ONE;
      if (E_bubble && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Randomized bench for pipe_stage_regs against a per-cycle reference model.
module tb_pipe_stage_regs;

  localparam int WORD  = 16;
  localparam int CNT_W = 4;
  localparam logic [WORD-1:0] RPC = 16'h0100;
  localparam int DW = 19 + 2 * WORD;
  localparam int EW = 27 + 3 * WORD;
  localparam int MW = 16 + 2 * WORD;
  localparam int WW = 15 + 2 * WORD;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Bubble images written out field by field.
  localparam logic [DW-1:0] D_BUB = {3'd1, 4'd1, 4'd0, 4'hF, 4'hF, {(2*WORD){1'b0}}};
  localparam logic [EW-1:0] E_BUB = {3'd1, 4'd1, 4'd0, {(3*WORD){1'b0}}, 16'hFFFF};
  localparam logic [MW-1:0] M_BUB = {3'd1, 4'd1, 1'b0, {(2*WORD){1'b0}}, 8'hFF};
  localparam logic [WW-1:0] W_BUB = {3'd1, 4'd1, {(2*WORD){1'b0}}, 8'hFF};

  logic clk, rst;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic [WORD-1:0] f_predPC;
  logic [DW-1:0] d_in;
  logic [EW-1:0] e_in;
  logic [MW-1:0] m_in;
  logic [WW-1:0] w_in;
  logic [WORD-1:0] F_predPC;
  logic [DW-1:0] D_bus;
  logic [EW-1:0] E_bus;
  logic [MW-1:0] M_bus;
  logic [WW-1:0] W_bus;
  logic halted, ctl_err;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  pipe_stage_regs #(.WORD(WORD), .CNT_W(CNT_W), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .f_predPC(f_predPC), .d_in(d_in), .e_in(e_in), .m_in(m_in), .w_in(w_in),
    .F_predPC(F_predPC), .D_bus(D_bus), .E_bus(E_bus), .M_bus(M_bus), .W_bus(W_bus),
    .halted(halted), .ctl_err(ctl_err), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [WORD-1:0] m_f;
  logic [DW-1:0] m_d;
  logic [EW-1:0] m_e;
  logic [MW-1:0] m_m;
  logic [WW-1:0] m_w;
  bit m_halt, m_err;
  int m_sc, m_bc;

  // One clock edge of the bank, stated as the behaviour rules.
  task automatic model_step();
    int st;
    bit stop;
    if (rst) begin
      m_f = RPC; m_d = D_BUB; m_e = E_BUB; m_m = M_BUB; m_w = W_BUB;
      m_halt = 0; m_err = 0; m_sc = 0; m_bc = 0;
      return;
    end
    if (m_halt) return;
    st = int'(m_w[WW-1 -: 3]);
    stop = W_stall && (st >= 2) && (st <= 4);
    if ((D_stall && D_bubble) || (W_stall && st == 1)) m_err = 1;
    if (F_stall && m_sc < CNT_MAX) m_sc++;
    if (E_bubble && m_bc < CNT_MAX) m_bc++;
    if (!F_stall) m_f = f_predPC;
    if (!D_stall) m_d = D_bubble ? D_BUB : d_in;
    m_e = E_bubble ? E_BUB : e_in;
    m_m = M_bubble ? M_BUB : m_in;
    if (!W_stall) m_w = w_in;
    m_halt = stop;
  endtask

  task automatic check_all();
    chk("F_predPC", 128'(F_predPC), 128'(m_f));
    chk("D_bus", 128'(D_bus), 128'(m_d));
    chk("E_bus", 128'(E_bus), 128'(m_e));
    chk("M_bus", 128'(M_bus), 128'(m_m));
    chk("W_bus", 128'(W_bus), 128'(m_w));
    chk("halted", 128'(halted), 128'(m_halt));
    chk("ctl_err", 128'(ctl_err), 128'(m_err));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_sc));
    chk("bubble_cnt", 128'(bubble_cnt), 128'(m_bc));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] with_hdr(input logic [127:0] v, input int w,
                                            input logic [2:0] st, input logic [3:0] ic);
    v[w-1 -: 3] = st;
    v[w-4 -: 4] = ic;
    return v;
  endfunction

  function automatic logic [2:0] rnd_stat();
    return ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
  endfunction

  task automatic rand_inputs();
    F_stall  = ($urandom_range(0, 3) == 0);
    D_stall  = ($urandom_range(0, 4) == 0);
    D_bubble = ($urandom_range(0, 4) == 0);
    E_bubble = ($urandom_range(0, 3) == 0);
    M_bubble = ($urandom_range(0, 4) == 0);
    W_stall  = ($urandom_range(0, 11) == 0);
    f_predPC = WORD'($urandom());
    d_in = DW'(with_hdr(rnd(), DW, rnd_stat(), 4'($urandom_range(0, 11))));
    e_in = EW'(with_hdr(rnd(), EW, rnd_stat(), 4'($urandom_range(0, 11))));
    m_in = MW'(with_hdr(rnd(), MW, rnd_stat(), 4'($urandom_range(0, 11))));
    w_in = WW'(with_hdr(rnd(), WW, rnd_stat(), 4'($urandom_range(0, 11))));
  endtask

  task automatic quiet_ctl();
    F_stall = 0; D_stall = 0; D_bubble = 0; E_bubble = 0; M_bubble = 0; W_stall = 0;
  endtask

  logic [DW-1:0] held_d;
  logic [CNT_W-1:0] snap_sc, snap_bc;

  initial begin
    rst = 1;
    quiet_ctl();
    f_predPC = '0; d_in = '0; e_in = '0; m_in = '0; w_in = '0;
    m_f = '0; m_d = '0; m_e = '0; m_m = '0; m_w = '0;
    m_halt = 0; m_err = 0; m_sc = 0; m_bc = 0;

    // reset state
    step();
    chk("rst_pc", 128'(F_predPC), 128'(RPC));
    chk("rst_d_icode", 128'(D_bus[DW-4 -: 4]), 128'(1));
    rst = 0;

    // free run with fetch icode 2
    for (int i = 0; i < 5; i++) begin
      f_predPC = WORD'($urandom());
      d_in = DW'(with_hdr(rnd(), DW, 3'd1, 4'd2));
      e_in = EW'(with_hdr(rnd(), EW, 3'd1, 4'd3));
      m_in = MW'(with_hdr(rnd(), MW, 3'd1, 4'd4));
      w_in = WW'(with_hdr(rnd(), WW, 3'd1, 4'd5));
      step();
      if (i == 0) chk("d_icode_load", 128'(D_bus[DW-4 -: 4]), 128'(2));
    end

    // D stall for two cycles while d_in moves
    held_d = m_d;
    D_stall = 1;
    for (int i = 0; i < 2; i++) begin
      d_in = DW'(rnd());
      step();
      chk("d_hold", 128'(D_bus), 128'(held_d));
    end
    chk("stall_cnt_untouched", 128'(stall_cnt), 128'(0));
    D_stall = 0;

    // one E bubble with icode 6 on the input
    e_in = EW'(with_hdr(rnd(), EW, 3'd1, 4'd6));
    E_bubble = 1;
    step();
    chk("e_bubble_bus", 128'(E_bus), 128'(E_BUB));
    chk("e_bubble_dste", 128'(E_bus[15:12]), 128'(15));
    chk("bubble_cnt_one", 128'(bubble_cnt), 128'(1));
    E_bubble = 0;

    // D stall and bubble together
    held_d = m_d;
    D_stall = 1; D_bubble = 1;
    step();
    chk("d_stall_wins", 128'(D_bus), 128'(held_d));
    chk("ctl_err_set", 128'(ctl_err), 128'(1));
    D_stall = 0; D_bubble = 0;
    for (int i = 0; i < 3; i++) step();
    chk("ctl_err_sticky", 128'(ctl_err), 128'(1));
    rst = 1; step(); rst = 0;
    chk("ctl_err_clear", 128'(ctl_err), 128'(0));

    // stall counter saturation
    F_stall = 1;
    for (int i = 0; i < 20; i++) step();
    chk("stall_sat", 128'(stall_cnt), 128'(CNT_MAX));
    F_stall = 0;

    // halt: load HLT into W, then stall W
    w_in = WW'(with_hdr(rnd(), WW, 3'd2, 4'd0));
    step();
    W_stall = 1;
    step();
    chk("halted_set", 128'(halted), 128'(1));
    snap_sc = stall_cnt; snap_bc = bubble_cnt;
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      F_stall = 1; E_bubble = 1;
      step();
    end
    chk("halt_sc_frozen", 128'(stall_cnt), 128'(snap_sc));
    chk("halt_bc_frozen", 128'(bubble_cnt), 128'(snap_bc));
    chk("halted_sticky", 128'(halted), 128'(1));
    rst = 1; step(); rst = 0;
    chk("halted_clear", 128'(halted), 128'(0));

    // random traffic, with occasional resets to leave halt
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 29) == 0);
      step();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
